mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 ihit  in  1  pipeline advance strobe.
REQ-005 aluout_out, store_out, baddr_out, jaddr_out, npc_out  in  32 each  EX/MEM register outputs.
REQ-006 dest_out  in  5  destination register.
REQ-007 zero_out  in  1  ALU zero flag.
REQ-008 WBctrl_out  in  4  write-back controls; bit3 = halt.
REQ-009 MEMctrl_out  in  5  memory controls: bit0 = read, bit1 = write, bit2 = beq, bit3 = bne, bit4 = jump.
REQ-010 dhit  in  1  data-cache hit/acknowledge.
REQ-011 dmemload  in  32  read data.
REQ-012 dmemREN, dmemWEN  out  1 each  data request strobes.
REQ-013 dmemaddr, dmemstore  out  32 each  request address and write data.
REQ-014 mem_stall  out  1  holds upstream pipeline.
REQ-015 pcsel  out  2  next-PC select: 00 = sequential, 01 = branch, 10 = jump.
REQ-016 pc_target  out  32  redirect target.
REQ-017 flush  out  1  squash younger stages.
REQ-018 wb_load, wb_alu, wb_npc  out  32 each  MEM/WB register data outputs.
REQ-019 wb_dest  out  5; wb_WBctrl  out  4  MEM/WB register control outputs.
REQ-020 halt  out  1  sticky halt.
REQ-021 stall_cnt  out  8  saturating count of stall cycles.

Function
REQ-022 memop SHALL equal MEMctrl_out[0] | MEMctrl_out[1], forced to 0 while halt = 1.
REQ-023 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-024 IDLE transitions:
- memop & dhit -> DONE
- memop & ~dhit -> REQ
- otherwise stay in IDLE.
REQ-025 REQ transitions:
- dhit -> DONE
- otherwise stay in REQ.
REQ-026 DONE transitions:
- ihit -> IDLE
- otherwise stay in DONE; no new request is issued.
REQ-027 Request strobes (combinational):
- dmemWEN = MEMctrl_out[1] & memop & state ∈ {IDLE, REQ}
- dmemREN = MEMctrl_out[0] & ~MEMctrl_out[1] & memop & state ∈ {IDLE, REQ}; write has priority when both bits are set.
REQ-028 dmemaddr SHALL equal aluout_out and dmemstore SHALL equal store_out, unconditionally.
REQ-029 On the dhit cycle of a read, dmemload SHALL be captured into a 32-bit load buffer; on a write, the buffer SHALL load 0.
REQ-030 mem_stall SHALL be 1 iff (state = IDLE & memop) or state = REQ; it SHALL be 0 in DONE.
REQ-031 Branch/jump resolution (combinational):
- taken = (MEMctrl_out[2] & zero_out) | (MEMctrl_out[3] & ~zero_out)
- jump (bit4) has priority: pcsel = 10, pc_target = jaddr_out
- else if taken: pcsel = 01, pc_target = baddr_out
- else: pcsel = 00, pc_target = npc_out.
REQ-032 flush SHALL equal (pcsel ≠ 00) & ~mem_stall.
REQ-033 The MEM/WB register SHALL load on a rising edge with ihit & ~mem_stall:
- wb_load = load buffer if state = DONE, else 0
- wb_alu = aluout_out
- wb_npc = npc_out
- wb_dest = dest_out
- wb_WBctrl = WBctrl_out.
Otherwise it SHALL hold.
REQ-034 halt SHALL set on the edge where the MEM/WB register loads with WBctrl_out[3] = 1, and SHALL clear only on reset.
REQ-035 stall_cnt SHALL increment on each edge with mem_stall = 1 and saturate at 255.
REQ-036 If ihit is asserted in REQ, it SHALL be ignored (no MEM/WB load).
REQ-037 If dhit arrives in IDLE without memop, it SHALL be ignored.

Reset
REQ-038 While nRST = 0 (asynchronous assertion):
- state = IDLE
- load buffer, wb_* outputs and stall_cnt = 0
- halt = 0.
REQ-039 Reset asserted mid-request (state REQ) SHALL return the FSM to IDLE with dmemREN = dmemWEN = 0 once memop is deasserted; no MEM/WB load occurs.

Verification
REQ-040 Load, aluout_out = 0x100, dhit held low 3 cycles, dmemload = 0xDEADBEEF -> mem_stall high 4 cycles; DONE; on ihit, wb_load = 0xDEADBEEF; stall_cnt = 4.
REQ-041 Store with same-cycle dhit -> dmemWEN = 1 for 1 cycle, dmemstore = store_out, mem_stall pulses once, wb_load = 0.
REQ-042 beq with zero = 1, baddr = 0x40 -> pcsel = 01, pc_target = 0x40, flush = 1; bne with zero = 1 -> pcsel = 00, flush = 0.
REQ-043 jump + beq taken, jaddr = 0x200 -> pcsel = 10, pc_target = 0x200.
REQ-044 WBctrl[3] = 1 advanced by ihit -> halt = 1; a subsequent load -> no dmemREN, mem_stall = 0.
REQ-045 nRST pulsed in REQ and 300 forced stall cycles -> all outputs return to 0; stall_cnt saturates at 255 before the reset.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: data-cache request FSM, branch/jump resolution and the MEM/WB register.
// Also tracks a sticky halt flag and a saturating count of stall cycles.
module mem_stage (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] aluout_out,
  input  logic [31:0] store_out,
  input  logic [31:0] baddr_out,
  input  logic [31:0] jaddr_out,
  input  logic [31:0] npc_out,
  input  logic [4:0]  dest_out,
  input  logic        zero_out,
  input  logic [3:0]  WBctrl_out,
  input  logic [4:0]  MEMctrl_out,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [1:0]  pcsel,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic [31:0] wb_load,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_npc,
  output logic [4:0]  wb_dest,
  output logic [3:0]  wb_WBctrl,
  output logic        halt,
  output logic [7:0]  stall_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] lbuf_q;
  logic        memop;
  logic        req_active;
  logic        taken;
  logic        wb_en;

  assign memop      = (MEMctrl_out[0] | MEMctrl_out[1]) & ~halt;
  assign req_active = memop & ((state_q == StIdle) | (state_q == StReq));

  assign dmemWEN   = MEMctrl_out[1] & req_active;
  assign dmemREN   = MEMctrl_out[0] & ~MEMctrl_out[1] & req_active;
  assign dmemaddr  = aluout_out;
  assign dmemstore = store_out;

  assign mem_stall = ((state_q == StIdle) & memop) | (state_q == StReq);
  assign wb_en     = ihit & ~mem_stall;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (memop) state_d = dhit ? StDone : StReq;
      StReq:  if (dhit)  state_d = StDone;
      StDone: if (ihit)  state_d = StIdle;
      default:           state_d = StIdle;
    endcase
  end

  // Jump outranks a taken branch.
  assign taken = (MEMctrl_out[2] & zero_out) | (MEMctrl_out[3] & ~zero_out);

  always_comb begin
    pcsel     = 2'b00;
    pc_target = npc_out;
    if (MEMctrl_out[4]) begin
      pcsel     = 2'b10;
      pc_target = jaddr_out;
    end else if (taken) begin
      pcsel     = 2'b01;
      pc_target = baddr_out;
    end
  end

  assign flush = (pcsel != 2'b00) & ~mem_stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture on the acknowledge cycle; stores leave zero so wb_load is clean.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lbuf_q <= '0;
    end else if (mem_stall && dhit) begin
      lbuf_q <= MEMctrl_out[1] ? 32'h0 : dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_load   <= '0;
      wb_alu    <= '0;
      wb_npc    <= '0;
      wb_dest   <= '0;
      wb_WBctrl <= '0;
      halt      <= 1'b0;
    end else if (wb_en) begin
      wb_load   <= (state_q == StDone) ? lbuf_q : 32'h0;
      wb_alu    <= aluout_out;
      wb_npc    <= npc_out;
      wb_dest   <= dest_out;
      wb_WBctrl <= WBctrl_out;
      if (WBctrl_out[3]) halt <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (mem_stall && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: branch vector table, directed multi-cycle sequences and
// randomized traffic checked against a flag-based behavioural model.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, zero_out, dhit;
  logic [31:0] aluout_out, store_out, baddr_out, jaddr_out, npc_out, dmemload;
  logic [4:0]  dest_out, MEMctrl_out;
  logic [3:0]  WBctrl_out;
  logic        dmemREN, dmemWEN, mem_stall, flush, halt;
  logic [31:0] dmemaddr, dmemstore, pc_target, wb_load, wb_alu, wb_npc;
  logic [1:0]  pcsel;
  logic [4:0]  wb_dest;
  logic [3:0]  wb_WBctrl;
  logic [7:0]  stall_cnt;

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .aluout_out(aluout_out), .store_out(store_out),
    .baddr_out(baddr_out), .jaddr_out(jaddr_out), .npc_out(npc_out), .dest_out(dest_out),
    .zero_out(zero_out), .WBctrl_out(WBctrl_out), .MEMctrl_out(MEMctrl_out), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .pcsel(pcsel), .pc_target(pc_target),
    .flush(flush), .wb_load(wb_load), .wb_alu(wb_alu), .wb_npc(wb_npc), .wb_dest(wb_dest),
    .wb_WBctrl(wb_WBctrl), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ihit = 0; zero_out = 0; dhit = 0; aluout_out = 0; store_out = 0; baddr_out = 0;
    jaddr_out = 0; npc_out = 0; dmemload = 0; dest_out = 0; MEMctrl_out = 0; WBctrl_out = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_inputs();
    nRST = 0;
    #2;
    nRST = 1;
  endtask

  // Model: a request is either outstanding (m_wait) or served and awaiting ihit (m_done).
  logic        m_wait, m_done, m_halt;
  logic [31:0] m_buf, m_load, m_alu, m_npc;
  logic [4:0]  m_dest;
  logic [3:0]  m_wbc;
  int          m_cnt;

  task automatic model_reset();
    m_wait = 0; m_done = 0; m_halt = 0; m_buf = 0; m_load = 0; m_alu = 0; m_npc = 0;
    m_dest = 0; m_wbc = 0; m_cnt = 0;
  endtask

  typedef struct {
    logic [4:0]  mc;
    logic        zero;
    logic [1:0]  pcsel;
    logic [31:0] target;
    logic        flush;
  } br_vec_t;

  br_vec_t vecs[8];

  initial begin
    logic        memop, e_stall, active, e_wen, e_ren, e_flush;
    logic [1:0]  e_pcsel;
    logic [31:0] e_target;

    vecs[0] = '{5'b00100, 1'b1, 2'b01, 32'h40,  1'b1};  // beq taken
    vecs[1] = '{5'b01000, 1'b1, 2'b00, 32'h8,   1'b0};  // bne not taken
    vecs[2] = '{5'b01000, 1'b0, 2'b01, 32'h40,  1'b1};  // bne taken
    vecs[3] = '{5'b00100, 1'b0, 2'b00, 32'h8,   1'b0};  // beq not taken
    vecs[4] = '{5'b10100, 1'b1, 2'b10, 32'h200, 1'b1};  // jump beats beq
    vecs[5] = '{5'b10000, 1'b0, 2'b10, 32'h200, 1'b1};  // plain jump
    vecs[6] = '{5'b00101, 1'b1, 2'b01, 32'h40,  1'b0};  // taken but stalled by load
    vecs[7] = '{5'b00000, 1'b1, 2'b00, 32'h8,   1'b0};

    clear_inputs();
    nRST = 0;
    #12;
    chk("rst_state_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_wb_load", wb_load, 32'h0);
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_stall_cnt", {24'h0, stall_cnt}, 32'h0);

    // Branch table under reset keeps the FSM parked in IDLE.
    jaddr_out = 32'h200; baddr_out = 32'h40; npc_out = 32'h8;
    for (int i = 0; i < 8; i++) begin
      MEMctrl_out = vecs[i].mc;
      zero_out    = vecs[i].zero;
      #1;
      chk($sformatf("vec%0d_pcsel", i), {30'h0, pcsel}, {30'h0, vecs[i].pcsel});
      chk($sformatf("vec%0d_target", i), pc_target, vecs[i].target);
      chk($sformatf("vec%0d_flush", i), {31'h0, flush}, {31'h0, vecs[i].flush});
    end

    // Load with three miss cycles then hit.
    do_reset();
    MEMctrl_out = 5'b00001; aluout_out = 32'h100; dmemload = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1;
      chk($sformatf("ld_stall%0d", i), {31'h0, mem_stall}, 32'h1);
      chk($sformatf("ld_ren%0d", i), {31'h0, dmemREN}, 32'h1);
      chk($sformatf("ld_addr%0d", i), dmemaddr, 32'h100);
      @(negedge CLK);
    end
    dhit = 0;
    #1;
    chk("ld_done_stall", {31'h0, mem_stall}, 32'h0);
    chk("ld_done_ren", {31'h0, dmemREN}, 32'h0);
    chk("ld_stall_cnt", {24'h0, stall_cnt}, 32'd4);
    ihit = 1;
    @(negedge CLK);
    chk("ld_wb_load", wb_load, 32'hDEADBEEF);
    chk("ld_wb_alu", wb_alu, 32'h100);

    // Store acknowledged in the same cycle.
    ihit = 0; MEMctrl_out = 5'b00010; store_out = 32'hCAFE0001; dhit = 1;
    #1;
    chk("st_wen", {31'h0, dmemWEN}, 32'h1);
    chk("st_ren", {31'h0, dmemREN}, 32'h0);
    chk("st_store", dmemstore, 32'hCAFE0001);
    chk("st_stall", {31'h0, mem_stall}, 32'h1);
    @(negedge CLK);
    dhit = 0;
    #1;
    chk("st_wen_done", {31'h0, dmemWEN}, 32'h0);
    chk("st_stall_done", {31'h0, mem_stall}, 32'h0);
    ihit = 1;
    @(negedge CLK);
    chk("st_wb_load", wb_load, 32'h0);
    chk("st_stall_cnt", {24'h0, stall_cnt}, 32'd5);

    // Halt then a load that must be suppressed.
    do_reset();
    WBctrl_out = 4'b1000; ihit = 1;
    @(negedge CLK);
    chk("halt_set", {31'h0, halt}, 32'h1);
    chk("halt_wbctrl", {28'h0, wb_WBctrl}, 32'h8);
    WBctrl_out = 0; ihit = 0; MEMctrl_out = 5'b00001;
    #1;
    chk("halt_no_ren", {31'h0, dmemREN}, 32'h0);
    chk("halt_no_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge CLK);
    chk("halt_sticky", {31'h0, halt}, 32'h1);

    // Long stall, saturation, then reset asserted in REQ.
    do_reset();
    aluout_out = 32'h1234; npc_out = 32'h44; dest_out = 5'd7; WBctrl_out = 4'b0101; ihit = 1;
    @(negedge CLK);
    chk("pre_wb_alu", wb_alu, 32'h1234);
    ihit = 1; MEMctrl_out = 5'b00001; dhit = 0; WBctrl_out = 0;
    repeat (300) @(negedge CLK);
    chk("sat_cnt", {24'h0, stall_cnt}, 32'd255);
    chk("sat_stall", {31'h0, mem_stall}, 32'h1);
    chk("req_ignore_ihit", wb_alu, 32'h1234);
    #1 nRST = 0;
    #1;
    chk("arst_cnt", {24'h0, stall_cnt}, 32'h0);
    chk("arst_wb_alu", wb_alu, 32'h0);
    chk("arst_wbctrl", {28'h0, wb_WBctrl}, 32'h0);
    MEMctrl_out = 0; ihit = 0;
    #1;
    chk("arst_ren", {31'h0, dmemREN}, 32'h0);
    chk("arst_wen", {31'h0, dmemWEN}, 32'h0);
    chk("arst_stall", {31'h0, mem_stall}, 32'h0);
    nRST = 1;
    @(negedge CLK);
    chk("arst_idle_cnt", {24'h0, stall_cnt}, 32'h0);

    // Randomized traffic against the model.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 250; cyc++) begin
        @(negedge CLK);
        ihit = 1'($urandom); dhit = 1'($urandom); zero_out = 1'($urandom);
        MEMctrl_out = 5'($urandom);
        WBctrl_out = {($urandom_range(0, 63) == 0), 3'($urandom)};
        aluout_out = $urandom; store_out = $urandom; baddr_out = $urandom;
        jaddr_out = $urandom; npc_out = $urandom; dmemload = $urandom; dest_out = 5'($urandom);
        #1;
        memop   = (MEMctrl_out[0] | MEMctrl_out[1]) & ~m_halt;
        e_stall = m_wait | (~m_done & memop);
        active  = memop & ~m_done;
        e_wen   = MEMctrl_out[1] & active;
        e_ren   = MEMctrl_out[0] & ~MEMctrl_out[1] & active;
        if (MEMctrl_out[4]) begin
          e_pcsel = 2'b10; e_target = jaddr_out;
        end else if ((MEMctrl_out[2] & zero_out) | (MEMctrl_out[3] & ~zero_out)) begin
          e_pcsel = 2'b01; e_target = baddr_out;
        end else begin
          e_pcsel = 2'b00; e_target = npc_out;
        end
        e_flush = (e_pcsel != 2'b00) & ~e_stall;
        chk("rnd_stall", {31'h0, mem_stall}, {31'h0, e_stall});
        chk("rnd_ren_wen", {30'h0, dmemREN, dmemWEN}, {30'h0, e_ren, e_wen});
        chk("rnd_pcsel", {30'h0, pcsel}, {30'h0, e_pcsel});
        chk("rnd_target", pc_target, e_target);
        chk("rnd_flush", {31'h0, flush}, {31'h0, e_flush});
        chk("rnd_addr", dmemaddr, aluout_out);
        chk("rnd_store", dmemstore, store_out);
        chk("rnd_wb_load", wb_load, m_load);
        chk("rnd_wb_alu", wb_alu, m_alu);
        chk("rnd_wb_npc", wb_npc, m_npc);
        chk("rnd_wb_ctl", {23'h0, wb_dest, wb_WBctrl}, {23'h0, m_dest, m_wbc});
        chk("rnd_halt", {31'h0, halt}, {31'h0, m_halt});
        chk("rnd_cnt", {24'h0, stall_cnt}, m_cnt);
        @(posedge CLK);
        if (ihit && !e_stall) begin
          m_load = m_done ? m_buf : 32'h0;
          m_alu = aluout_out; m_npc = npc_out; m_dest = dest_out; m_wbc = WBctrl_out;
          if (WBctrl_out[3]) m_halt = 1;
        end
        if (e_stall && dhit) m_buf = MEMctrl_out[1] ? 32'h0 : dmemload;
        if (e_stall && m_cnt < 255) m_cnt++;
        if (m_done) begin
          if (ihit) m_done = 0;
        end else if (m_wait) begin
          if (dhit) begin m_wait = 0; m_done = 1; end
        end else if (memop) begin
          if (dhit) m_done = 1;
          else m_wait = 1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
